// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with an RV32 load/store unit: SB/SH/SW, LB/LH/LW/LBU/LHU,
// misalignment and range flags, and a one-word-per-cycle clear sequence after reset.
module dmem_lsu #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_st_en,
    input  logic        i_ld_en,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_misaligned,
    output logic        o_oob
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_ptr_q;
    logic [AW-1:0]   clr_ptr_d;
    logic            clearing;

    logic [31:0]     off;
    logic [AW-1:0]   word;
    logic [1:0]      lane;
    logic            is_half;
    logic            is_word;
    logic            ld_legal;
    logic            st_legal;
    logic            access_ok;
    logic            misaligned;
    logic            out_of_range;
    logic            do_load;
    logic            do_store;
    logic [3:0]      st_be;
    logic [31:0]     wdata_rep;
    logic [7:0]      rd_bytes [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_ext;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    assign clr_ptr_d = clr_ptr_q + AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_ptr_q <= clr_ptr_d;
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign o_busy   = (state_q == ST_CLEAR) | i_rst;
    assign clearing = (state_q == ST_CLEAR) & ~i_rst;

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    assign off          = i_addr - BASE_ADDR;
    assign word         = off[AW+1:2];
    assign lane         = off[1:0];
    assign out_of_range = (off >= SPAN);

    always_comb begin
        is_half  = 1'b0;
        is_word  = 1'b0;
        ld_legal = 1'b0;
        st_legal = 1'b0;
        case (i_funct3)
            3'b000: begin ld_legal = 1'b1; st_legal = 1'b1; end
            3'b001: begin ld_legal = 1'b1; st_legal = 1'b1; is_half = 1'b1; end
            3'b010: begin ld_legal = 1'b1; st_legal = 1'b1; is_word = 1'b1; end
            3'b100: begin ld_legal = 1'b1; end
            3'b101: begin ld_legal = 1'b1; is_half = 1'b1; end
            default: begin end
        endcase
    end

    assign access_ok = (i_ld_en | i_st_en)
                     & (~i_ld_en | ld_legal)
                     & (~i_st_en | st_legal)
                     & ~o_busy;

    assign misaligned   = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign o_misaligned = access_ok & misaligned;
    assign o_oob        = access_ok & out_of_range;

    assign do_load  = i_ld_en & access_ok & ~misaligned & ~out_of_range;
    assign do_store = i_st_en & access_ok & ~misaligned & ~out_of_range;

    // ------------------------------------------------------------------
    // Store lane enables and data steering
    // ------------------------------------------------------------------
    always_comb begin
        st_be     = 4'b0000;
        wdata_rep = i_wdata;
        if (is_word) begin
            st_be     = 4'b1111;
            wdata_rep = i_wdata;
        end else if (is_half) begin
            st_be     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {i_wdata[15:0], i_wdata[15:0]};
        end else begin
            st_be     = 4'b0001 << lane;
            wdata_rep = {4{i_wdata[7:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane so each lane writes independently
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0]    lane_mem [DEPTH];
        logic          lane_we;
        logic [AW-1:0] lane_waddr;
        logic [7:0]    lane_wdata;

        assign lane_we    = clearing | (do_store & st_be[gi]);
        assign lane_waddr = clearing ? clr_ptr_q : word;
        assign lane_wdata = clearing ? 8'h00 : wdata_rep[gi*8 +: 8];

        always_ff @(posedge i_clk) begin
            if (lane_we) begin
                lane_mem[lane_waddr] <= lane_wdata;
            end
        end

        assign rd_bytes[gi] = lane_mem[word];
    end

    // ------------------------------------------------------------------
    // Load extraction and extension (reads pre-store contents)
    // ------------------------------------------------------------------
    assign byte_sel = rd_bytes[lane];
    assign half_sel = lane[1] ? {rd_bytes[3], rd_bytes[2]} : {rd_bytes[1], rd_bytes[0]};

    always_comb begin
        load_ext = 32'h0;
        case (i_funct3)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            3'b010:  load_ext = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
            default: load_ext = 32'h0;
        endcase
    end

    assign o_rdata = do_load ? load_ext : 32'h0;

endmodule
